// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - array of leaky integrate-and-fire neurons sharing one input current
// Optional refractory counters enabled by defining LIF_REFRACTORY_EN.
module lif_neuron_array #(
  parameter int NUM_NEURONS   = 8,
  parameter int IN_W          = 8,
  parameter int STATE_W       = 8,
  parameter int LEAK_SHIFT    = 1,
  parameter int THRESH_INIT   = 200,
  parameter int BIAS_BASE     = 10,
  parameter int BIAS_STEP     = 1,
  parameter int REFRAC_CYCLES = 3,
  localparam int SEL_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_step_en,
  input  logic [IN_W-1:0]        i_current,
  input  logic                   i_thresh_wr,
  input  logic [STATE_W-1:0]     i_thresh_in,
  input  logic [SEL_W-1:0]       i_sel,
  output logic [STATE_W-1:0]     o_state_out,
  output logic [NUM_NEURONS-1:0] o_spikes,
  output logic                   o_spike_any
);

  localparam int IW = ((STATE_W > IN_W) ? STATE_W : IN_W) + 2;
  localparam logic [IW-1:0] SAT_MAX = IW'((2 ** STATE_W) - 1);

  logic [STATE_W-1:0]     r_state [NUM_NEURONS];
  logic [STATE_W-1:0]     r_thresh;
  logic [STATE_W-1:0]     r_state_out;
  logic [NUM_NEURONS-1:0] r_spikes;
  logic                   r_spike_any;

  logic [NUM_NEURONS-1:0] w_refr;
  logic [NUM_NEURONS-1:0] w_fire;
  logic [IW-1:0]          w_in    [NUM_NEURONS];
  logic [IW-1:0]          w_sum   [NUM_NEURONS];
  logic [IW-1:0]          w_sat   [NUM_NEURONS];
  logic [STATE_W-1:0]     w_next  [NUM_NEURONS];
  logic [STATE_W-1:0]     w_upd   [NUM_NEURONS];
  logic [STATE_W-1:0]     w_sel_state;
  logic [STATE_W-1:0]     w_thresh_new;

`ifdef LIF_REFRACTORY_EN
  logic [3:0] r_refrac [NUM_NEURONS];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_refrac[i] <= '0;
    end else if (i_step_en) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (w_refr[i])      r_refrac[i] <= r_refrac[i] - 4'd1;
        else if (w_fire[i]) r_refrac[i] <= 4'(REFRAC_CYCLES);
      end
    end
  end

  always_comb begin
    w_refr = '0;
    for (int i = 0; i < NUM_NEURONS; i++) w_refr[i] = (r_refrac[i] != 4'd0);
  end
`else
  always_comb w_refr = '0;
`endif

  // Internal width has two spare bits so leak+input never overflows before saturation.
  always_comb begin
    w_fire = '0;
    w_sel_state = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      w_in[i]   = w_refr[i] ? '0
                : IW'(i_current) + IW'(BIAS_BASE) + IW'(i * BIAS_STEP);
      w_sum[i]  = IW'(r_state[i]) - (IW'(r_state[i]) >> LEAK_SHIFT) + w_in[i];
      w_sat[i]  = (w_sum[i] > SAT_MAX) ? SAT_MAX : w_sum[i];
      w_fire[i] = !w_refr[i] && (w_sat[i] >= IW'(r_thresh));
      w_next[i] = w_fire[i] ? STATE_W'(w_sat[i] - IW'(r_thresh)) : STATE_W'(w_sat[i]);
      w_upd[i]  = i_step_en ? w_next[i] : r_state[i];
      if (SEL_W'(i) == i_sel) w_sel_state = w_upd[i];
    end
  end

  assign w_thresh_new = (i_thresh_in == '0) ? STATE_W'(1) : i_thresh_in;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_state[i] <= '0;
      r_spikes    <= '0;
      r_spike_any <= 1'b0;
      r_state_out <= '0;
      r_thresh    <= STATE_W'(THRESH_INIT);
    end else begin
      if (i_step_en) begin
        for (int i = 0; i < NUM_NEURONS; i++) r_state[i] <= w_next[i];
        r_spikes    <= w_fire;
        r_spike_any <= |w_fire;
      end else begin
        r_spikes    <= '0;
        r_spike_any <= 1'b0;
      end
      // Readout shows the state as it will be after this edge.
      r_state_out <= w_sel_state;
      if (i_thresh_wr) r_thresh <= w_thresh_new;
    end
  end

  assign o_state_out = r_state_out;
  assign o_spikes    = r_spikes;
  assign o_spike_any = r_spike_any;

endmodule
